// File: rtl/bcd_scan_counter_if.sv
// Bus bundle for bcd_scan_counter: count controls in, BCD value and display scan out.
// The master side drives the controls; the slave side (the counter) returns its outputs.
interface bcd_scan_counter_if;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] value;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        wrap;
    logic        load_err;

    modport master (
        output en, up, load, load_val,
        input  value, digit, an, wrap, load_err
    );

    modport slave (
        input  en, up, load, load_val,
        output value, digit, an, wrap, load_err
    );
endinterface

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with prescaled stepping, checked loads and a 4-position display scan.
// value/wrap/load_err/an are registered (1 cycle); digit is combinational from the scan position and value.
module bcd_scan_counter #(
    parameter int CNT_DIV  = 5000000,
    parameter int SCAN_DIV = 50000,
    parameter int LZ_BLANK = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_scan_counter_if.slave bus
);

    localparam int CW = (CNT_DIV  > 1) ? $clog2(CNT_DIV)  : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CNT_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q,   cnt_d;
    logic [SW-1:0] scan_q,  scan_d;
    logic [1:0]    sel_q,   sel_d;
    logic [3:0]    an_q,    an_d;
    logic [15:0]   value_q, value_d;
    logic          wrap_q,  wrap_d;
    logic          lerr_q,  lerr_d;

    logic          step;
    logic          load_ok;
    logic [15:0]   inc_val;
    logic [15:0]   dec_val;
    logic [1:0]    hi_pos;
    logic [3:0]    digit_raw;
    logic          blank;

    assign step = bus.en && (cnt_q == CNT_MAX);

    always_comb begin : bcd_arith
        logic carry;
        logic borrow;
        carry   = 1'b1;
        borrow  = 1'b1;
        inc_val = value_q;
        dec_val = value_q;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (value_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (value_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.load_val[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    // Any load, accepted or not, swallows a coincident step.
    always_comb begin
        cnt_d   = cnt_q;
        value_d = value_q;
        wrap_d  = 1'b0;
        lerr_d  = 1'b0;
        if (bus.load) begin
            if (load_ok) begin
                value_d = bus.load_val;
                cnt_d   = '0;
            end else begin
                lerr_d  = 1'b1;
            end
        end else if (bus.en) begin
            if (step) begin
                cnt_d   = '0;
                value_d = bus.up ? inc_val : dec_val;
                wrap_d  = bus.up ? (value_q == 16'h9999) : (value_q == 16'h0000);
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        scan_d = scan_q + SW'(1);
        sel_d  = sel_q;
        if (scan_q == SCAN_MAX) begin
            scan_d = '0;
            sel_d  = sel_q + 2'd1;
        end
        an_d = ~(4'b0001 << sel_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            scan_q  <= '0;
            sel_q   <= 2'd0;
            an_q    <= 4'b1110;
            value_q <= 16'h0000;
            wrap_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            scan_q  <= scan_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            value_q <= value_d;
            wrap_q  <= wrap_d;
            lerr_q  <= lerr_d;
        end
    end

    // Highest nonzero position; an all-zero value still shows a single 0 in position 0.
    always_comb begin
        hi_pos = 2'd0;
        if (value_q[7:4]   != 4'd0) hi_pos = 2'd1;
        if (value_q[11:8]  != 4'd0) hi_pos = 2'd2;
        if (value_q[15:12] != 4'd0) hi_pos = 2'd3;
    end

    always_comb begin
        case (sel_q)
            2'd1:    digit_raw = value_q[7:4];
            2'd2:    digit_raw = value_q[11:8];
            2'd3:    digit_raw = value_q[15:12];
            default: digit_raw = value_q[3:0];
        endcase
    end

    assign blank = (LZ_BLANK != 0) && (sel_q > hi_pos);

    assign bus.value    = value_q;
    assign bus.digit    = blank ? 4'hF : digit_raw;
    assign bus.an       = an_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = lerr_q;

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 Parameter CNT_DIV, default 5000000: clk cycles per count step while enabled; legal range >= 1.
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles each digit position stays selected; legal range >= 1.
REQ-003 Parameter LZ_BLANK, default 0: 1 enables leading-zero blanking on the digit output.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 en  input  1  count enable; gates the count prescaler.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  one-cycle request to load load_val.
REQ-009 load_val  input  16  four packed BCD digits; [3:0] is the least significant digit.
REQ-010 value  output  16  current four-digit BCD count; registered.
REQ-011 digit  output  4  BCD code for the selected position; drives the downstream 7-segment decoder.
REQ-012 an  output  4  active-low one-hot position select; bit n low means digit n is shown.
REQ-013 wrap  output  1  one-cycle pulse on count wrap-around.
REQ-014 load_err  output  1  one-cycle pulse on a rejected load.

Function
REQ-015 Count prescaler: counts 0..CNT_DIV-1 while en=1, holds while en=0; asserts an internal step when it equals CNT_DIV-1 with en=1, then returns to 0.
REQ-016 CNT_DIV=1: step asserts on every cycle with en=1.
REQ-017 Step with up=1: BCD increment with decimal carry per digit (9 -> 0 plus carry); value is updated on the edge where step is asserted.
REQ-018 Step with up=0: BCD decrement with decimal borrow per digit (0 -> 9 plus borrow).
REQ-019 Wrap-around: 9999 -> 0000 on increment and 0000 -> 9999 on decrement; wrap is 1 for exactly the cycle following that edge and 0 at all other times.
REQ-020 Load: every nibble of load_val <= 9 -> value = load_val on the next edge, and the count prescaler clears to 0.
REQ-021 Load with any nibble > 9 -> value and prescaler unchanged; load_err is 1 for the following cycle.
REQ-022 Priority: rst_n low > load > step; a step coincident with a load (accepted or rejected) is discarded and does not assert wrap.
REQ-023 Scan divider: free-running 0..SCAN_DIV-1, independent of en; at SCAN_DIV-1 the 2-bit position sel advances 0 -> 1 -> 2 -> 3 -> 0.
REQ-024 an = 4'b1111 with bit sel cleared; exactly one bit is low at all times, including during reset.
REQ-025 digit is combinational from sel and value: digit = value[4*sel+3 : 4*sel].
REQ-026 LZ_BLANK=1: digit = 4'hF (downstream decoder renders blank) for any position above the highest nonzero digit; position 0 is never blanked.
REQ-027 LZ_BLANK=0: digit is never blanked.
REQ-028 value never holds a nibble > 9.

Reset
REQ-029 rst_n low at an edge -> value = 16'h0000, sel = 0, an = 4'b1110, digit = 4'h0, wrap = 0, load_err = 0, and both dividers = 0.
REQ-030 Reset mid-count or coincident with load/en overrides them; the first step after release occurs CNT_DIV enabled cycles later.

Verification
REQ-031 rst_n low 2 cycles with load=1, load_val=16'h1234, en=1 -> value 0000, an 1110, digit 0, wrap 0.
REQ-032 CNT_DIV=1: load 16'h0999, then up=1, en=1 for one cycle -> value 16'h1000, wrap stays 0.
REQ-033 Load 16'h9999, up=1, one step -> value 16'h0000, one wrap pulse; load 16'h0000, up=0, one step -> value 16'h9999, one wrap pulse.
REQ-034 Load 16'h12A4 -> load_err pulses once, value unchanged; load+step in the same cycle -> value = load_val, no increment.
REQ-035 CNT_DIV=3, en toggled 1,0,1,1 -> exactly one step, on the 4th cycle.
REQ-036 SCAN_DIV=4, LZ_BLANK=1, value 16'h0042 -> an cycles 1110,1101,1011,0111 with 4 cycles each; digit = 2, 4, F, F respectively.
